// File: rtl/seq_divider.sv
// seq_divider -- sequential radix-2 restoring divider, one quotient bit per clock.
//
// Companion of the Booth multiplier in the arithmetic unit. It uses the same
// start/done handshake. The result is registered and held until the result of
// the next accepted operation is written.
//
// Optional feature macro: DIV_SIGNED_EN
//   Undefined (default): unsigned operands. ADJUST passes Q/R through unchanged.
//   Defined            : two's-complement operands. Division runs on magnitudes,
//                        and ADJUST applies the signs. The quotient truncates
//                        toward zero. The remainder takes the sign of the dividend.
//
// Parameters
//   WIDTH        operand / quotient / remainder width (>= 2)
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        request, sampled only while idle
//   dividend     dividend, sampled with start
//   divisor      divisor, sampled with start
//   busy         high in every state except IDLE
//   done         one-cycle pulse while the result is valid
//   quotient     registered quotient
//   remainder    registered remainder
//   div_by_zero  registered divide-by-zero flag, valid from done
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CALC   = 2'd1,
      S_ADJUST = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] d_reg;
   logic [WIDTH:0]   r_reg;
   logic [CW-1:0]    cnt;

   // R is never larger than D after a step, so R's MSB is always 0 here. It
   // still feeds the shift so that the full R register takes part in the trial.
   logic [WIDTH+1:0] r_shift;
   logic [WIDTH+1:0] trial;
   logic             trial_neg;

   assign r_shift   = {r_reg, q_reg[WIDTH-1]};
   assign trial     = r_shift - {2'b00, d_reg};
   assign trial_neg = trial[WIDTH+1];

`ifdef DIV_SIGNED_EN
   logic q_neg;
   logic r_neg;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
      return (~x) + ONE;
   endfunction

   // Magnitude of a two's-complement value. The most negative value maps to
   // 2^(WIDTH-1), which is still representable as an unsigned magnitude.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? negate(x) : x;
   endfunction
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = S_IDLE;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = (divisor == '0) ? S_DONE : S_CALC;
            else       state_nxt = S_IDLE;
         end
         S_CALC:   state_nxt = (cnt == '0) ? S_ADJUST : S_CALC;
         S_ADJUST: state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Outputs: pure decodes of the state register, with no path from the inputs
   always_comb begin
      busy = (state != S_IDLE);
      done = (state == S_DONE);
   end

   // Datapath and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_reg       <= '0;
         d_reg       <= '0;
         r_reg       <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end else begin
`ifdef DIV_SIGNED_EN
                     q_reg <= magnitude(dividend);
                     d_reg <= magnitude(divisor);
                     q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                     r_neg <= dividend[WIDTH-1];
`else
                     q_reg <= dividend;
                     d_reg <= divisor;
`endif
                     r_reg       <= '0;
                     cnt         <= CW'(WIDTH - 1);
                     div_by_zero <= 1'b0;
                  end
               end
            end
            S_CALC: begin
               // Restoring step: keep the shifted R when the trial goes negative
               r_reg <= trial_neg ? r_shift[WIDTH:0] : trial[WIDTH:0];
               q_reg <= {q_reg[WIDTH-2:0], ~trial_neg};
               if (cnt != '0) cnt <= cnt - CW'(1);
            end
            S_ADJUST: begin
`ifdef DIV_SIGNED_EN
               quotient  <= q_neg ? negate(q_reg) : q_reg;
               remainder <= r_neg ? negate(r_reg[WIDTH-1:0]) : r_reg[WIDTH-1:0];
`else
               quotient  <= q_reg;
               remainder <= r_reg[WIDTH-1:0];
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential radix-2 restoring divider and the inverse companion of the Booth multiplier: one quotient bit per clock, controlled by a four-state FSM. It sits beside the multiplier in the arithmetic unit and shares its start/finish handshake style. The result is registered and held until the next accepted operation.

## Interface
- `WIDTH`, default 8: operand, quotient and remainder width (≥ 2).
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE.
- `dividend` in WIDTH: dividend, sampled with `start`.
- `divisor` in WIDTH: divisor, sampled with `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the result is valid.
- `quotient` out WIDTH: registered quotient.
- `remainder` out WIDTH: registered remainder.
- `div_by_zero` out 1: registered flag, valid from `done`.

## Operation
- States: IDLE, CALC, ADJUST, DONE.
- IDLE, `start`=1, `divisor`≠0:
  - Load magnitude registers Q←dividend, D←divisor, R (WIDTH+1 bits)←0.
  - Load iteration counter ← WIDTH−1; clear `div_by_zero`.
  - Go to CALC.
- IDLE, `start`=1, `divisor`=0:
  - Set `quotient` to all ones, `remainder`←dividend (raw bits), `div_by_zero`←1.
  - Go to DONE.
- CALC, per cycle:
  - Shift {R,Q} left by 1; compute trial = R − {0,D}.
  - If trial ≥ 0: R←trial and Q[0]←1. Otherwise R is unchanged and Q[0]←0.
  - When counter = 0, go to ADJUST; otherwise decrement the counter.
- ADJUST: `quotient`←Q and `remainder`←R[WIDTH-1:0], with the sign correction described under Configuration. Go to DONE.
- DONE: `done`=1 for this cycle only. Go to IDLE unconditionally.
- `start` outside IDLE, including in DONE, is ignored. No queuing.
- `quotient`, `remainder` and `div_by_zero` hold their values from DONE until the next accepted `start`'s result is written.
- Reset at any time:
  - State returns to IDLE.
  - All internal registers and all outputs go to 0.
  - Any in-flight operation is discarded; no `done` is produced.
- Unknown state encoding: return to IDLE.

## Timing
- Reset values: `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0.
- Normal operation, with `start` sampled at edge k:
  - CALC spans cycles k+1 … k+WIDTH.
  - ADJUST is cycle k+WIDTH+1.
  - `done`=1 in cycle k+WIDTH+2, so latency is WIDTH+2 cycles.
- Divide by zero: `done`=1 in cycle k+1, so latency is 1 cycle.
- `busy` rises in the cycle after `start` is accepted. It falls when the FSM re-enters IDLE, one cycle after `done`.
- Back-to-back operation: a new `start` can be accepted in the first IDLE cycle after DONE. Throughput is one operation per WIDTH+3 cycles.
- `done` and `busy` are registered state decodes, so they carry no combinational path from the inputs.

## Configuration
- `DIV_SIGNED_EN` defined:
  - Operands are two's complement. At load, D and Q take the absolute values.
  - Quotient sign = sign(dividend) XOR sign(divisor), truncating toward zero.
  - Remainder takes the sign of the dividend. Negation is applied in ADJUST.
  - −2^(WIDTH−1) / −1 wraps: quotient = −2^(WIDTH−1), remainder = 0, no flag.
  - Divide by zero behaves as in unsigned mode.
- `DIV_SIGNED_EN` undefined:
  - Operands are unsigned and ADJUST passes Q/R through unchanged.
  - Timing is identical in both modes.

## Test plan
- WIDTH=8, unsigned, 100/7 → `quotient`=14, `remainder`=2, `div_by_zero`=0; `done` exactly 10 cycles after `start`; `busy` high for 10 cycles.
- 5/0 → `quotient`=0xFF, `remainder`=5, `div_by_zero`=1; `done` 1 cycle after `start`. A following 255/1 → `quotient`=255, `remainder`=0, `div_by_zero`=0.
- `DIV_SIGNED_EN`: −7/2 → `quotient`=0xFD (−3), `remainder`=0xFF (−1). 7/−2 → 0xFD, 1. −128/−1 → 0x80, 0.
- `start` pulsed with 9/3 during CALC and during DONE of a 200/13 operation → only one `done`, result 15 r 5, outputs unchanged afterwards.
- `rst` asserted mid-CALC of 100/7 → all outputs 0 and state IDLE immediately. No `done` follows, and a new 50/5 after release gives 10 r 0.
- Exhaustive or random sweep of all 8-bit operand pairs in both modes, checked against a reference model; `done` latency checked for every pair.
